pc_sequencer: RTL and testbench

//  Owns the fetch PC register and sequences next-PC selection for the 5-stage pipeline.

---
 rtl/pc_sequencer_pkg.sv | 22 ++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: next-PC opcodes and FSM states.
package pc_sequencer_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NPCOP_W = 3;

    localparam logic [NPCOP_W-1:0] NPC_PLUS4  = 3'd0;
    localparam logic [NPCOP_W-1:0] NPC_BRANCH = 3'd1;
    localparam logic [NPCOP_W-1:0] NPC_JUMP   = 3'd2;
    localparam logic [NPCOP_W-1:0] NPC_JALR   = 3'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Fetch PC register and next-PC sequencing: EX redirects, hazard stalls and the
// imem req/ready handshake, including draining a fetch issued on a squashed path.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               ex_valid,
    input  logic [2:0]         ex_npcop,
    input  logic               ex_zero,
    input  logic [31:0]        ex_pc_plus_imm,
    input  logic [31:0]        ex_aluout,
    input  logic               imem_ready,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    output logic [31:0]        pc_if,
    output logic               if_valid,
    output logic               flush_ifid,
    output logic               flush_idex,
    output logic [CNT_W-1:0]   redirect_cnt
);

    state_e      state;
    logic [31:0] drain_addr;
    logic        take;
    logic [31:0] tgt;

    // Redirect decode of the EX-stage instruction.
    always_comb begin
        take = 1'b0;
        tgt  = ex_pc_plus_imm;
        if (ex_valid) begin
            case (ex_npcop)
                NPC_JUMP, NPC_JALR: take = 1'b1;
                NPC_BRANCH:         take = ex_zero;
                default:            take = 1'b0;
            endcase
        end
        if (ex_npcop == NPC_JALR) begin
            tgt = ex_aluout & ~32'd1;
        end
    end

    // Flushes and capture strobe must act in the redirect cycle itself.
    assign imem_req   = !rst;
    assign imem_addr  = (state == ST_DRAIN) ? drain_addr : pc_if;
    assign flush_ifid = !rst && take;
    assign flush_idex = !rst && take;
    assign if_valid   = !rst && !take && !stall && imem_ready && (state != ST_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_if        <= RESET_PC;
            state        <= ST_RUN;
            drain_addr   <= '0;
            redirect_cnt <= '0;
        end else if (take) begin
            pc_if <= tgt;
            if (redirect_cnt != '1) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
            // The in-flight request keeps its original address until it completes.
            if (state != ST_DRAIN) begin
                if (imem_ready) begin
                    state <= ST_RUN;
                end else begin
                    state      <= ST_DRAIN;
                    drain_addr <= pc_if;
                end
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            pc_if <= pc_inc(pc_if);
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem_ready) begin
                        state <= ST_RUN;
                        if (!stall) begin
                            pc_if <= pc_inc(pc_if);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (imem_ready) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then randomized traffic,
// checked against a fetch-transaction model (outstanding / squashed request).
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int unsigned TB_CNT_W = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic                clk = 1'b0;
    logic                rst, stall, ex_valid, ex_zero, imem_ready;
    logic [2:0]          ex_npcop;
    logic [31:0]         ex_pc_plus_imm, ex_aluout;
    logic                imem_req, if_valid, flush_ifid, flush_idex;
    logic [31:0]         imem_addr, pc_if;
    logic [TB_CNT_W-1:0] redirect_cnt;

    pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
        .ex_npcop(ex_npcop), .ex_zero(ex_zero), .ex_pc_plus_imm(ex_pc_plus_imm),
        .ex_aluout(ex_aluout), .imem_ready(imem_ready), .imem_req(imem_req),
        .imem_addr(imem_addr), .pc_if(pc_if), .if_valid(if_valid),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                req;
        logic [31:0]         addr;
        logic [31:0]         pc;
        logic                ifv;
        logic                flush;
        logic [TB_CNT_W-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a fetch is either idle, outstanding on the live path,
    // or outstanding on a squashed path (its address kept in m_saddr).
    logic [31:0]         m_pc = RST_PC;
    logic                m_outst = 1'b0;
    logic                m_squashed = 1'b0;
    logic [31:0]         m_saddr = '0;
    int                  m_redirects = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [TB_CNT_W-1:0] sat_cnt(input int n);
        int lim = (1 << TB_CNT_W) - 1;
        return (n > lim) ? TB_CNT_W'(lim) : TB_CNT_W'(n);
    endfunction

    task automatic step(input logic r, input logic s, input logic v, input logic [2:0] op,
                        input logic z, input logic [31:0] pimm, input logic [31:0] alu,
                        input logic rdy);
        exp_t        e;
        logic        tk;
        logic [31:0] t;
        @(negedge clk);
        rst = r; stall = s; ex_valid = v; ex_npcop = op; ex_zero = z;
        ex_pc_plus_imm = pimm; ex_aluout = alu; imem_ready = rdy;

        tk = v && (op == NPC_JUMP || op == NPC_JALR || (op == NPC_BRANCH && z));
        t  = (op == NPC_JALR) ? {alu[31:1], 1'b0} : pimm;
        e.req   = !r;
        e.addr  = m_squashed ? m_saddr : m_pc;
        e.pc    = m_pc;
        e.ifv   = !r && !tk && !s && rdy && !m_squashed;
        e.flush = !r && tk;
        e.cnt   = sat_cnt(m_redirects);
        sbq.push_back(e);

        if (r) begin
            m_pc = RST_PC; m_outst = 0; m_squashed = 0; m_saddr = '0; m_redirects = 0;
        end else if (tk) begin
            m_redirects++;
            if (!m_squashed && !rdy) begin
                m_squashed = 1; m_saddr = m_pc;
            end
            m_outst = 0;
            m_pc = t;
        end else if (m_squashed) begin
            if (rdy) m_squashed = 0;
        end else if (s) begin
            if (m_outst && rdy) m_outst = 0;
        end else if (rdy) begin
            m_pc = m_pc + 32'd4;
            m_outst = 0;
        end else begin
            m_outst = 1;
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, NPC_PLUS4, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    task automatic jump(input logic [31:0] t, input logic s, input logic rdy);
        step(1'b0, s, 1'b1, NPC_JUMP, 1'b0, t, 32'h0, rdy);
    endtask

    task automatic expect_pc(input string nm, input logic [31:0] v);
        #3;
        chk(nm, pc_if, v);
    endtask

    // Monitor: DUT outputs are compared against the queued expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("imem_req",     32'(imem_req),     32'(e.req));
            chk("imem_addr",    imem_addr,         e.addr);
            chk("pc_if",        pc_if,             e.pc);
            chk("if_valid",     32'(if_valid),     32'(e.ifv));
            chk("flush_ifid",   32'(flush_ifid),   32'(e.flush));
            chk("flush_idex",   32'(flush_idex),   32'(e.flush));
            chk("redirect_cnt", 32'(redirect_cnt), 32'(e.cnt));
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_npcop = NPC_PLUS4; ex_zero = 1'b0;
        ex_pc_plus_imm = '0; ex_aluout = '0; imem_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Reset then straight-line fetch.
        step(1, 0, 0, NPC_PLUS4, 0, 0, 0, 1);
        step(1, 0, 0, NPC_PLUS4, 0, 0, 0, 1);
        idle(1); expect_pc("seq0", 32'h0);
        idle(1); expect_pc("seq4", 32'h4);
        idle(1); expect_pc("seq8", 32'h8);
        idle(1); expect_pc("seq12", 32'hC);

        // Taken and not-taken branch, then JALR with the low bit cleared.
        step(0, 0, 1, NPC_BRANCH, 1, 32'h40, 0, 1);
        idle(1); expect_pc("br_taken", 32'h40);
        step(0, 0, 1, NPC_BRANCH, 0, 32'h80, 0, 1);
        idle(1); expect_pc("br_not_taken", 32'h48);
        step(0, 0, 1, NPC_JALR, 0, 32'h500, 32'h0000_0103, 1);
        idle(1); expect_pc("jalr", 32'h102);
        repeat (3) step(0, 1, 0, NPC_PLUS4, 0, 0, 0, 1);
        expect_pc("stall_hold", 32'h106);

        // Miss at 0x10, redirect while waiting: old address drained first.
        step(1, 0, 0, NPC_PLUS4, 0, 0, 0, 1);
        repeat (4) idle(1);
        idle(0);
        jump(32'h80, 0, 0);
        idle(0); #3; chk("drain_addr", imem_addr, 32'h10);
        idle(1);
        idle(1); expect_pc("post_drain", 32'h80);

        // Redirect beats stall; latest redirect in drain wins.
        jump(32'h200, 1, 1);
        idle(1); expect_pc("take_over_stall", 32'h200);
        idle(0);
        jump(32'h80, 0, 0);
        jump(32'hC0, 0, 0);
        idle(1);
        idle(1); expect_pc("latest_redirect", 32'hC0);

        // Counter saturation, then reset from WAIT.
        repeat (20) jump(32'h300, 0, 1);
        idle(1); #3; chk("cnt_sat", 32'(redirect_cnt), 32'hF);
        idle(0); idle(0);
        step(1, 0, 0, NPC_PLUS4, 0, 0, 0, 0);
        idle(1); expect_pc("rst_in_wait", RST_PC);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 4));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), op, 1'($urandom),
                 $urandom, $urandom, ($urandom_range(0, 2) != 0));
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        #5;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
